// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, encodings and state type for the fetch stage.
package fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_e;
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats stall beats load, otherwise a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr,
  output logic            o_valid
);
  logic [XLEN-1:0] r_pc, r_instr;
  logic            r_valid;
  // Bubbles and flushes keep the old pc; only instr and valid are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_instr <= NOP;
      r_valid <= 1'b0;
    end else if (i_flush || (!i_stall && !i_load)) begin
      r_instr <= NOP;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem request FSM and hold buffer feeding IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            id_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            if_id_valid
);
  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, r_addr, r_hold_pc, r_hold_instr, w_pc_nxt;
  logic            r_req, w_stall, w_ack, w_load;
  assign w_stall   = !pc_write || !id_write;
  assign w_ack     = r_req && imem_ready;
  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    if (branch_taken) begin
      w_pc_nxt    = align_word(branch_target);
      w_state_nxt = (r_state != HOLD && r_req && !imem_ready) ? DISCARD : FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ack && w_stall) w_state_nxt = HOLD;
          w_load   = w_ack && !w_stall;
          w_pc_nxt = w_load ? r_pc + XLEN'(4) : r_pc;
        end
        HOLD: begin
          w_load      = !w_stall;
          w_pc_nxt    = w_load ? r_pc + XLEN'(4) : r_pc;
          w_state_nxt = w_load ? FETCH : HOLD;
        end
        default: w_state_nxt = w_ack ? FETCH : DISCARD;
      endcase
    end
  end
  // A discarded request keeps its original address until the response is drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_req        <= 1'b0;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= (w_state_nxt == DISCARD) ? r_addr : w_pc_nxt;
      r_req   <= w_state_nxt != HOLD;
      if (branch_taken) begin
        r_hold_pc    <= '0;
        r_hold_instr <= '0;
      end else if (r_state == FETCH && w_ack && w_stall) begin
        r_hold_pc    <= r_pc;
        r_hold_instr <= imem_rdata;
      end
    end
  end
  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (branch_taken),
    .i_stall (w_stall),
    .i_load  (w_load),
    .i_pc    ((r_state == HOLD) ? r_hold_pc : r_pc),
    .i_instr ((r_state == HOLD) ? r_hold_instr : imem_rdata),
    .o_pc    (if_id_pc),
    .o_instr (if_id_instr),
    .o_valid (if_id_valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic against a flag-based fetch model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  logic clk = 0, rst_n = 1, pc_write = 1, id_write = 1, branch_taken = 0, imem_ready = 0;
  logic [31:0] branch_target = '0, imem_rdata = '0;
  logic imem_req, if_id_valid, w_req, w_valid;
  logic [31:0] imem_addr, if_id_pc, if_id_instr, w_addr, w_pc, w_instr;
  int n_chk = 0, n_pass = 0;
  logic m_req, m_drop, m_held, m_iv;
  logic [31:0] m_pc, m_addr, m_hpc, m_hins, m_ipc, m_iins;
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .id_write(id_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .id_write(id_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_pc(w_pc), .if_id_instr(w_instr), .if_id_valid(w_valid)
  );
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  task automatic check_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    chk("imem_addr", imem_addr, m_addr);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_instr", if_id_instr, m_iins);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_iv});
  endtask
  task automatic m_reset();
    m_req = 0; m_drop = 0; m_held = 0; m_pc = 0; m_addr = 0;
    m_hpc = 0; m_hins = 0; m_ipc = 0; m_iins = NOP; m_iv = 0;
  endtask
  // The model tracks "a response still owed to a dead request" and "one parked instruction".
  task automatic m_step(input bit stall, input bit br, input logic [31:0] tgt, input bit rdy);
    bit ack;
    ack = m_req && rdy;
    if (br) begin
      m_iins = NOP; m_iv = 0; m_held = 0;
      m_drop = m_req && !rdy;
      m_pc = tgt & 32'hFFFF_FFFC;
      if (!m_drop) m_addr = m_pc;
      m_req = 1;
    end else if (m_drop) begin
      if (ack) begin m_drop = 0; m_addr = m_pc; end
      if (!stall) begin m_iins = NOP; m_iv = 0; end
    end else if (m_held) begin
      if (!stall) begin
        m_ipc = m_hpc; m_iins = m_hins; m_iv = 1; m_held = 0;
        m_pc = m_pc + 4; m_addr = m_pc; m_req = 1;
      end
    end else if (ack && stall) begin
      m_held = 1; m_hpc = m_pc; m_hins = imem_rdata; m_req = 0;
    end else begin
      if (ack) begin
        m_ipc = m_pc; m_iins = imem_rdata; m_iv = 1; m_pc = m_pc + 4; m_addr = m_pc;
      end else if (!stall) begin
        m_iins = NOP; m_iv = 0;
      end
      m_req = 1;
    end
  endtask
  task automatic cyc(input bit pw, input bit iw, input bit br, input logic [31:0] tgt, input bit rdy);
    pc_write = pw; id_write = iw; branch_taken = br; branch_target = tgt; imem_ready = rdy;
    imem_rdata = memf(m_addr);
    m_step(!(pw && iw), br, tgt, rdy);
    @(posedge clk); #1;
    check_all();
  endtask
  task automatic do_reset();
    branch_taken = 0; imem_ready = 0; pc_write = 1; id_write = 1;
    #2 rst_n = 0;
    m_reset();
    #1 check_all();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h0000_0013);
    @(posedge clk); #1 rst_n = 1;
  endtask
  initial begin
    bit pw, iw, br, rdy;
    logic [31:0] tgt;
    // Streaming, with the wrapping instance fetching alongside.
    do_reset();
    cyc(1, 1, 0, 0, 1);
    chk("stream_first_addr", imem_addr, 32'h0);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0, 1);
    chk("wrap_addr1", w_addr, 32'h0);
    chk("wrap_ifid_pc", w_pc, 32'hFFFF_FFFC);
    for (int k = 0; k < 4; k++) begin
      chk("stream_pc", if_id_pc, 32'(4 * k));
      chk("stream_valid", {31'd0, if_id_valid}, 32'd1);
      cyc(1, 1, 0, 0, 1);
    end
    // Load-use stall while the response for 0x8 arrives.
    do_reset();
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("stall_hold_pc", if_id_pc, 32'h4);
    cyc(1, 1, 0, 0, 0);
    chk("stall_release_pc", if_id_pc, 32'h8);
    chk("stall_release_instr", if_id_instr, memf(32'h8));
    chk("stall_next_addr", imem_addr, 32'hC);
    cyc(1, 1, 0, 0, 1);
    chk("stall_no_dup", if_id_pc, 32'hC);
    // Redirect while the request to 0x10 is pending.
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0, 1);
    chk("redir_pending_addr", imem_addr, 32'h10);
    cyc(1, 1, 1, 32'h103, 0);
    chk("redir_old_addr", imem_addr, 32'h10);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    chk("redir_new_addr", imem_addr, 32'h100);
    chk("redir_dropped", {31'd0, if_id_valid}, 32'd0);
    cyc(1, 1, 0, 0, 1);
    chk("redir_arrive", if_id_pc, 32'h100);
    // Branch in the same cycle as a stall while holding.
    do_reset();
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 1, 32'h200, 0);
    chk("brstall_addr", imem_addr, 32'h200);
    chk("brstall_req", {31'd0, imem_req}, 32'd1);
    cyc(1, 1, 0, 0, 1);
    chk("brstall_ifid", if_id_pc, 32'h200);
    // Reset while draining a discarded request; the stale ready must be ignored.
    do_reset();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'h40, 0);
    do_reset();
    cyc(1, 1, 0, 0, 1);
    chk("rstdisc_addr", imem_addr, 32'h0);
    chk("rstdisc_stale", {31'd0, if_id_valid}, 32'd0);
    cyc(1, 1, 0, 0, 1);
    chk("rstdisc_first", if_id_pc, 32'h0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      pw = $urandom_range(0, 4) != 0;
      iw = $urandom_range(0, 4) != 0;
      br = $urandom_range(0, 15) == 0;
      rdy = $urandom_range(0, 1) == 1;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc(pw, iw, br, tgt, rdy);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pc_write  in  1  from hazard detection; 0 = hold PC
- id_write  in  1  from hazard detection; 0 = hold IF/ID
- branch_taken  in  1  EX-stage redirect, single-cycle pulse
- branch_target  in  32  redirect address
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  response valid this cycle
- imem_rdata  in  32  instruction word
- if_id_pc  out  32  PC of the instruction in IF/ID
- if_id_instr  out  32  instruction in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL allow at most one imem request outstanding; imem_addr SHALL be stable while imem_req=1 and imem_ready=0.
REQ-005 SHALL treat stall = !pc_write | !id_write, so both inputs low and either input low behave identically.
REQ-006 SHALL implement states FETCH, HOLD and DISCARD, held in a registered state machine.
REQ-007 FETCH: SHALL drive imem_req=1 and imem_addr=pc.
- On imem_ready with no stall: load IF/ID with {pc, imem_rdata, valid=1}, set pc<=pc+4, issue the next request on the following cycle.
- On imem_ready with stall: capture {pc, rdata} into the hold buffer, go to HOLD.
REQ-008 HOLD: SHALL drive imem_req=0 and keep IF/ID unchanged while stalled; on the first non-stall cycle it SHALL load IF/ID from the hold buffer, set pc<=pc+4 and return to FETCH.
REQ-009 With no stall and no instruction available (FETCH, imem_ready=0), IF/ID SHALL become a bubble: valid=0, instr=32'h0000_0013 (NOP), pc unchanged.
REQ-010 While stalled, IF/ID SHALL hold all three fields unchanged.
REQ-011 branch_taken SHALL take priority over stall and all other events, with these effects:
- pc<=branch_target with bits [1:0] forced to 0.
- IF/ID flushed to valid=0, instr=NOP.
- Hold buffer discarded.
REQ-012 branch_taken in FETCH with imem_ready=0 SHALL move to DISCARD. DISCARD keeps imem_req=1 at the old address until imem_ready, drops that response, and then enters FETCH at the new pc.
REQ-013 branch_taken in FETCH with imem_ready=1, or in HOLD, SHALL drop the response and enter FETCH at the new pc on the next cycle.
REQ-014 branch_taken in DISCARD SHALL update pc only and remain in DISCARD.
REQ-015 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-016 Fetch-to-IF/ID latency SHALL be one cycle after imem_ready in the no-stall case.

Reset
REQ-017 Reset SHALL set:
- pc=RESET_PC
- state=FETCH
- imem_req=0
- imem_addr=RESET_PC
- if_id_valid=0, if_id_instr=NOP, if_id_pc=0
- hold buffer cleared
REQ-018 On the first clock edge after reset release, imem_req SHALL rise with imem_addr=RESET_PC.
REQ-019 Reset asserted mid-request SHALL abandon the request immediately; any later imem_ready SHALL NOT be accepted until imem_req is re-asserted.

Structure
REQ-020 The shared package SHALL hold XLEN=32, the NOP encoding 32'h0000_0013 and the default reset PC.
REQ-021 The IF/ID register (with hold and flush) SHALL be a sub-module named if_id_reg; the PC, the state machine and the hold buffer stay in fetch_stage.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Streaming: imem_ready=1 every cycle, no stall -> if_id_pc steps 0,4,8,12 on successive cycles, valid=1.
- Load-use stall: id_write=pc_write=0 for 1 cycle while the response at 0x8 arrives -> IF/ID holds 0x4 for one extra cycle, then shows 0x8; 0x8 is neither lost nor duplicated.
- Redirect mid-request: branch_taken with target 0x103 while the request to 0x10 is pending, ready arrives 3 cycles later -> that data is dropped, the next imem_addr is 0x100, IF/ID shows NOP/valid=0 until 0x100 arrives.
- Branch during stall: branch_taken and stall in the same cycle -> flush wins, pc=target, HOLD is exited.
- Wrap: RESET_PC=32'hFFFF_FFFC -> the second fetch address is 0x0.
- Reset mid-DISCARD: rst_n low, then released -> the first request is at RESET_PC and the stale imem_ready is ignored.
